// File: rtl/onchip_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_loader_pkg
// Shared definitions for the on-chip RAM byte-stream loader:
//   - default geometry of the target RAM (word-address width, depth) and the
//     width of the byte-length input
//   - FSM state encoding (plain localparam constants on a 3-bit type so the
//     encoding is stable and visible on the debug port)
//   - tail_be(): byte-enable for a final word holding n = len mod 4 bytes
//   - lane_mask(): expands a 4-bit byte-enable into a 32-bit bit mask
// Optional feature macro used by the loader: LOADER_READBACK_VERIFY_EN
// -----------------------------------------------------------------------------
package onchip_mem_loader_pkg;

   localparam int LDR_ADDR_W = 12;
   localparam int LDR_DEPTH  = 2240;
   localparam int LDR_LEN_W  = 14;

   typedef logic [2:0] ldr_state_t;

   localparam ldr_state_t S_IDLE  = 3'd0;
   localparam ldr_state_t S_FILL  = 3'd1;
   localparam ldr_state_t S_WRITE = 3'd2;
   localparam ldr_state_t S_DONE  = 3'd3;
   localparam ldr_state_t S_RDBK  = 3'd4;
   localparam ldr_state_t S_CMP   = 3'd5;

   // n == 0 means the word is full (length is a multiple of 4).
   function automatic logic [3:0] tail_be(input logic [1:0] n);
      logic [3:0] be;
      case (n)
         2'd1:    be = 4'b0001;
         2'd2:    be = 4'b0011;
         2'd3:    be = 4'b0111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/onchip_loader_packer.sv
// -----------------------------------------------------------------------------
// onchip_loader_packer
// Packs accepted stream bytes little-endian into a 32-bit word and tracks how
// many bytes of the current load have been taken.
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         start of a new load: empties word, lane and byte count
//   accept        a byte is transferred this cycle (in_valid & in_ready)
//   in_data       the byte being transferred
//   word_done     current word has been handed to the RAM; empty the word
//   len_bytes     byte length of the current load (held by the loader)
//   word          packed word; lanes not yet filled read as 0
//   flush         the byte accepted this cycle completes a word or the load
//   all_in        every byte of the load has been accepted
// -----------------------------------------------------------------------------
module onchip_loader_packer
   import onchip_mem_loader_pkg::*;
#(
   parameter int LEN_W = LDR_LEN_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             accept,
   input  logic [7:0]       in_data,
   input  logic             word_done,
   input  logic [LEN_W-1:0] len_bytes,
   output logic [31:0]      word,
   output logic             flush,
   output logic             all_in
);

   logic [31:0]      word_q;
   logic [1:0]       lane_q;
   logic [LEN_W-1:0] byte_cnt_q;
   logic             last_byte;

   // The byte in flight this cycle is the final one of the load.
   assign last_byte = (byte_cnt_q + LEN_W'(1)) == len_bytes;
   assign flush     = accept && ((lane_q == 2'd3) || last_byte);
   assign all_in    = (byte_cnt_q == len_bytes);
   assign word      = word_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q     <= '0;
         lane_q     <= '0;
         byte_cnt_q <= '0;
      end else if (clear) begin
         word_q     <= '0;
         lane_q     <= '0;
         byte_cnt_q <= '0;
      end else if (word_done) begin
         // Clearing the whole word keeps unused lanes of a tail word at 0.
         word_q <= '0;
         lane_q <= '0;
      end else if (accept) begin
         word_q[{lane_q, 3'b000} +: 8] <= in_data;
         lane_q     <= lane_q + 2'd1;
         byte_cnt_q <= byte_cnt_q + LEN_W'(1);
      end
   end

endmodule

// File: rtl/onchip_mem_loader.sv
// -----------------------------------------------------------------------------
// onchip_mem_loader
// Loads a byte stream into the 32-bit single-port on-chip RAM: bytes are packed
// little-endian into words and written to consecutive word addresses starting
// at base_addr. Reports busy / done / sticky error to the controller.
// Optional feature (macro LOADER_READBACK_VERIFY_EN): every written word is read
// back and compared under its byte-enable mask; a mismatch sets error.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  one-cycle pulse, begins a load when idle
//   base_addr, len_bytes   load parameters, sampled on an accepted start
//   in_valid, in_data      byte stream input
//   in_ready               loader takes the byte this cycle
//   busy, done, error      status (done is a one-cycle pulse, error is sticky)
//   mem_*                  RAM interface (mem_readdata valid one cycle after
//                          the address is presented)
//   dbg_state              current FSM state (encoding in the package)
//
// Stream handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1; in_ready depends only on the FSM state (never on
// in_valid), and a byte offered while in_ready is 0 stays with the source.
// -----------------------------------------------------------------------------
module onchip_mem_loader
   import onchip_mem_loader_pkg::*;
#(
   parameter int ADDR_W = LDR_ADDR_W,
   parameter int DEPTH  = LDR_DEPTH,
   parameter int LEN_W  = LDR_LEN_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len_bytes,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   output logic              mem_clken,
   output logic              mem_reset_req,
   output logic [2:0]        dbg_state
);

   ldr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] word_idx_q;
   logic [LEN_W-1:0]  len_q;
   logic              error_q;

   logic              start_ok;
   logic [31:0]       words_need;
   logic [31:0]       span_end;
   logic              range_bad;
   logic              pk_accept;
   logic              pk_flush;
   logic              pk_all_in;
   logic [31:0]       pk_word;
   logic              word_end;
   logic              ram_active;
   logic [3:0]        be_cur;

   assign start_ok = (state_q == S_IDLE) && start;

   // One past the last word the load would touch; must not exceed DEPTH.
   // 32-bit arithmetic so neither the sum nor ceil(len/4) can wrap.
   assign words_need = (32'(len_bytes) + 32'd3) >> 2;
   assign span_end   = 32'(base_addr) + words_need;
   assign range_bad  = span_end > 32'(DEPTH);

   assign in_ready  = (state_q == S_FILL);
   assign pk_accept = in_ready && in_valid;

   // Only the word written once all bytes are in can be partial.
   assign be_cur = pk_all_in ? tail_be(len_q[1:0]) : 4'hF;

`ifdef LOADER_READBACK_VERIFY_EN
   logic rb_mismatch;
   assign rb_mismatch = ((mem_readdata ^ pk_word) & lane_mask(be_cur)) != 32'd0;
   assign word_end    = (state_q == S_CMP);
   assign ram_active  = (state_q == S_WRITE) || (state_q == S_RDBK);
`else
   logic unused_rdata;
   assign unused_rdata = ^mem_readdata;
   assign word_end     = (state_q == S_WRITE);
   assign ram_active   = (state_q == S_WRITE);
`endif

   onchip_loader_packer #(
      .LEN_W (LEN_W)
   ) u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (start_ok),
      .accept    (pk_accept),
      .in_data   (in_data),
      .word_done (word_end),
      .len_bytes (len_q),
      .word      (pk_word),
      .flush     (pk_flush),
      .all_in    (pk_all_in)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_bytes == '0)  state_d = S_DONE;
               else if (range_bad)   state_d = S_DONE;
               else                  state_d = S_FILL;
            end
         end
         // Leave on the edge that takes the word's last byte, so a full word
         // costs four FILL cycles plus the RAM sequence.
         S_FILL:  if (pk_flush) state_d = S_WRITE;
`ifdef LOADER_READBACK_VERIFY_EN
         S_WRITE: state_d = S_RDBK;
         S_RDBK:  state_d = S_CMP;
         S_CMP:   state_d = pk_all_in ? S_DONE : S_FILL;
`else
         S_WRITE: state_d = pk_all_in ? S_DONE : S_FILL;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         word_idx_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            base_q     <= base_addr;
            len_q      <= len_bytes;
            word_idx_q <= '0;
            // An empty load never touches the RAM, so it cannot be out of range.
            error_q    <= (len_bytes != '0) && range_bad;
         end else if (word_end) begin
            word_idx_q <= word_idx_q + ADDR_W'(1);
         end
`ifdef LOADER_READBACK_VERIFY_EN
         if ((state_q == S_CMP) && rb_mismatch) error_q <= 1'b1;
`endif
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign error = error_q;

   // The RAM sees nothing but zeros outside its access cycles.
   assign mem_chipselect = ram_active;
   assign mem_write      = (state_q == S_WRITE);
   assign mem_address    = ram_active ? (base_q + word_idx_q) : '0;
   assign mem_byteenable = ram_active ? be_cur : 4'h0;
   assign mem_writedata  = (state_q == S_WRITE) ? pk_word : 32'd0;
   assign mem_clken      = 1'b1;
   assign mem_reset_req  = 1'b0;
   assign dbg_state      = state_q;

endmodule
